// File: rtl/pipe_ctrl_unit_if.sv
// ID/EX control handshake and registered control bundle between the ID-side issue logic and pipe_ctrl_unit.
interface pipe_ctrl_unit_if #(
  parameter int OP_LEN  = 4,
  parameter int EXE_LEN = 4
);
  logic               op_valid;
  logic [OP_LEN-1:0]  opCode;
  logic               op_ready;
  logic               hazard_detected;
  logic               branch_taken;
  logic               ex_valid;
  logic [EXE_LEN-1:0] EXE_CMD;
  logic [1:0]         Branch_command;
  logic               branchEn;
  logic               Is_Imm;
  logic               ST_or_BNE;
  logic               WB_EN;
  logic               MEM_R_EN;
  logic               MEM_W_EN;
  logic               mc_busy;

  modport master (
    output op_valid, opCode, hazard_detected, branch_taken,
    input  op_ready, ex_valid, EXE_CMD, Branch_command, branchEn, Is_Imm,
           ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, mc_busy
  );

  modport slave (
    input  op_valid, opCode, hazard_detected, branch_taken,
    output op_ready, ex_valid, EXE_CMD, Branch_command, branchEn, Is_Imm,
           ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, mc_busy
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control unit: decodes opcodes into a registered EX/MEM/WB bundle, inserts bubbles on
// hazards, flushes on taken branches and holds multi-cycle MUL/DIV/MOD in EX for their latency.
module pipe_ctrl_unit #(
  parameter int OP_LEN  = 4,
  parameter int EXE_LEN = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_ctrl_unit_if.slave   bus
);

  // Opcode map; ALU ops reuse their opcode value as the EXE_CMD encoding.
  localparam logic [OP_LEN-1:0] OP_MOVR = OP_LEN'(0);
  localparam logic [OP_LEN-1:0] OP_ADD  = OP_LEN'(1);
  localparam logic [OP_LEN-1:0] OP_SUB  = OP_LEN'(2);
  localparam logic [OP_LEN-1:0] OP_MUL  = OP_LEN'(3);
  localparam logic [OP_LEN-1:0] OP_DIV  = OP_LEN'(4);
  localparam logic [OP_LEN-1:0] OP_MOD  = OP_LEN'(5);
  localparam logic [OP_LEN-1:0] OP_AND  = OP_LEN'(6);
  localparam logic [OP_LEN-1:0] OP_OR   = OP_LEN'(7);
  localparam logic [OP_LEN-1:0] OP_SHR  = OP_LEN'(8);
  localparam logic [OP_LEN-1:0] OP_SHL  = OP_LEN'(9);
  localparam logic [OP_LEN-1:0] OP_CMP  = OP_LEN'(10);
  localparam logic [OP_LEN-1:0] OP_MOVI = OP_LEN'(11);
  localparam logic [OP_LEN-1:0] OP_LDR  = OP_LEN'(12);
  localparam logic [OP_LEN-1:0] OP_STR  = OP_LEN'(13);
  localparam logic [OP_LEN-1:0] OP_BEQ  = OP_LEN'(14);
  localparam logic [OP_LEN-1:0] OP_JMP  = OP_LEN'(15);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef struct packed {
    logic [EXE_LEN-1:0] exe_cmd;
    logic [1:0]         br_cmd;
    logic               br_en;
    logic               is_imm;
    logic               st_bne;
    logic               wb_en;
    logic               mem_r;
    logic               mem_w;
  } ctrl_t;

  typedef enum logic {S_RUN = 1'b0, S_MULTI = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              bundle_q, bundle_d;
  logic               ex_valid_q, ex_valid_d;
  logic               mc_busy_q, mc_busy_d;
  logic               wb_keep_q, wb_keep_d;

  ctrl_t              dec;
  logic [CNT_W-1:0]   op_lat;
  logic               ready;

  always_comb begin
    dec    = '0;
    op_lat = CNT_W'(1);
    unique case (bus.opCode)
      OP_ADD, OP_SUB, OP_MOVR, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
        dec.exe_cmd = EXE_LEN'(bus.opCode);
        dec.wb_en   = 1'b1;
      end
      OP_MUL: begin
        dec.exe_cmd = EXE_LEN'(bus.opCode);
        dec.wb_en   = 1'b1;
        op_lat      = CNT_W'(MUL_LAT);
      end
      OP_DIV, OP_MOD: begin
        dec.exe_cmd = EXE_LEN'(bus.opCode);
        dec.wb_en   = 1'b1;
        op_lat      = CNT_W'(DIV_LAT);
      end
      OP_CMP: dec.exe_cmd = EXE_LEN'(OP_CMP);
      OP_MOVI: begin
        dec.exe_cmd = EXE_LEN'(OP_MOVI);
        dec.wb_en   = 1'b1;
        dec.is_imm  = 1'b1;
      end
      OP_LDR: begin
        dec.exe_cmd = EXE_LEN'(OP_ADD);
        dec.wb_en   = 1'b1;
        dec.st_bne  = 1'b1;
        dec.mem_r   = 1'b1;
      end
      OP_STR: begin
        dec.exe_cmd = EXE_LEN'(OP_ADD);
        dec.st_bne  = 1'b1;
        dec.mem_w   = 1'b1;
      end
      OP_BEQ, OP_JMP: begin
        dec.br_cmd = bus.opCode[1:0];
        dec.br_en  = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bundle_d   = bundle_q;
    ex_valid_d = ex_valid_q;
    mc_busy_d  = mc_busy_q;
    wb_keep_d  = wb_keep_q;
    ready      = 1'b0;
    unique case (state_q)
      S_RUN: begin
        bundle_d   = '0;
        ex_valid_d = 1'b0;
        mc_busy_d  = 1'b0;
        cnt_d      = '0;
        if (bus.branch_taken) begin
          ready = 1'b1;
        end else if (bus.hazard_detected) begin
          ready = 1'b0;
        end else if (bus.op_valid) begin
          ready      = 1'b1;
          bundle_d   = dec;
          ex_valid_d = 1'b1;
          if (op_lat > CNT_W'(1)) begin
            // Write-back is suppressed until the op's final EX cycle.
            cnt_d          = op_lat - CNT_W'(1);
            mc_busy_d      = 1'b1;
            wb_keep_d      = dec.wb_en;
            bundle_d.wb_en = 1'b0;
            state_d        = S_MULTI;
          end
        end
      end
      S_MULTI: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d          = '0;
          mc_busy_d      = 1'b0;
          bundle_d.wb_en = wb_keep_q;
          state_d        = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      bundle_q   <= '0;
      ex_valid_q <= 1'b0;
      mc_busy_q  <= 1'b0;
      wb_keep_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bundle_q   <= bundle_d;
      ex_valid_q <= ex_valid_d;
      mc_busy_q  <= mc_busy_d;
      wb_keep_q  <= wb_keep_d;
    end
  end

  assign bus.op_ready       = ready & rst_n;
  assign bus.ex_valid       = ex_valid_q;
  assign bus.EXE_CMD        = bundle_q.exe_cmd;
  assign bus.Branch_command = bundle_q.br_cmd;
  assign bus.branchEn       = bundle_q.br_en;
  assign bus.Is_Imm         = bundle_q.is_imm;
  assign bus.ST_or_BNE      = bundle_q.st_bne;
  assign bus.WB_EN          = bundle_q.wb_en;
  assign bus.MEM_R_EN       = bundle_q.mem_r;
  assign bus.MEM_W_EN       = bundle_q.mem_w;
  assign bus.mc_busy        = mc_busy_q;

  // A branch cannot resolve while a multi-cycle op owns EX.
  a_no_branch_in_multi: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_MULTI) |-> !bus.branch_taken);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: reset, decode sweep, hazard bubble, multi-cycle ops, flush, reset mid-op.
module tb_pipe_ctrl_unit;
  localparam int OPW = 5;  // one spare opcode bit so unknown opcodes are reachable

  localparam logic [OPW-1:0] MOVR = 5'd0,  ADD = 5'd1,  SUB = 5'd2,  MUL = 5'd3;
  localparam logic [OPW-1:0] DIV  = 5'd4,  MOD = 5'd5,  AND_ = 5'd6, OR_ = 5'd7;
  localparam logic [OPW-1:0] SHR  = 5'd8,  SHL = 5'd9,  CMP = 5'd10, MOVI = 5'd11;
  localparam logic [OPW-1:0] LDR  = 5'd12, STR = 5'd13, BEQ = 5'd14, JMP = 5'd15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.OP_LEN(OPW), .EXE_LEN(4)) bus ();

  pipe_ctrl_unit #(.OP_LEN(OPW), .EXE_LEN(4), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {ex_valid, EXE_CMD[3:0], Branch_command[1:0], branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, mc_busy}
  logic [13:0] obs;
  assign obs = {bus.ex_valid, bus.EXE_CMD, bus.Branch_command, bus.branchEn, bus.Is_Imm,
                bus.ST_or_BNE, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.mc_busy};

  // Expected bundle of an accepted instruction, straight from the decode table.
  function automatic logic [13:0] exp_dec(input logic [OPW-1:0] op);
    case (op)
      MOVR, ADD, SUB, MUL, DIV, MOD, AND_, OR_, SHR, SHL:
                return {1'b1, op[3:0], 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      CMP:      return {1'b1, 4'd10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      MOVI:     return {1'b1, 4'd11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      LDR:      return {1'b1, 4'd1,  2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      STR:      return {1'b1, 4'd1,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      BEQ:      return {1'b1, 4'd0,  2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      JMP:      return {1'b1, 4'd0,  2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      default:  return {1'b1, 13'd0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-18s bundle=%b", tag, obs);
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    checks++;
    assert (bus.op_ready === exp) else begin
      errors++;
      $error("FAIL %s: op_ready observed=%b expected=%b", tag, bus.op_ready, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [OPW-1:0] op, input logic hz, input logic br);
    bus.op_valid        = v;
    bus.opCode          = op;
    bus.hazard_detected = hz;
    bus.branch_taken    = br;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multi-cycle op from RUN; returns during its final EX cycle (a RUN cycle).
  task automatic run_multi(input string name, input logic [OPW-1:0] op, input int lat);
    logic [13:0] e;
    drive(1'b1, op, 1'b0, 1'b0);
    chk_rdy({name, "_accept"}, 1'b1);
    tick();
    for (int c = 1; c <= lat; c++) begin
      e = exp_dec(op);
      if (c < lat) begin
        e[3] = 1'b0;
        e[0] = 1'b1;
      end
      chk($sformatf("%s_ex%0d", name, c), e);
      if (c < lat) begin
        drive(1'b1, ADD, c[0], 1'b0);
        chk_rdy($sformatf("%s_rdy%0d", name, c), 1'b0);
        tick();
      end
    end
  endtask

  logic [OPW-1:0] sweep [15];

  initial begin
    sweep = '{MOVR, ADD, SUB, AND_, OR_, SHR, SHL, CMP, MOVI, LDR, STR, BEQ, JMP, 5'h10, 5'h1F};

    // T1 reset with a valid ADD pending
    drive(1'b1, ADD, 1'b0, 1'b0);
    chk_rdy("rst_rdy0", 1'b0);
    tick();
    chk("rst_cyc1", 14'd0);
    chk_rdy("rst_rdy1", 1'b0);
    tick();
    chk("rst_cyc2", 14'd0);
    rst_n = 1'b1;
    #2;
    chk_rdy("rel_rdy", 1'b1);
    tick();
    chk("rel_add", exp_dec(ADD));

    // T2 decode sweep, back-to-back
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, sweep[i], 1'b0, 1'b0);
      chk_rdy($sformatf("sw_rdy_%0h", sweep[i]), 1'b1);
      tick();
      chk($sformatf("sw_op_%0h", sweep[i]), exp_dec(sweep[i]));
    end

    // idle -> bubble
    drive(1'b0, ADD, 1'b0, 1'b0);
    tick();
    chk("idle_bubble", 14'd0);

    // T3 load-use hazard
    drive(1'b1, LDR, 1'b0, 1'b0);
    tick();
    chk("hz_ldr", exp_dec(LDR));
    drive(1'b1, ADD, 1'b1, 1'b0);
    chk_rdy("hz_rdy", 1'b0);
    tick();
    chk("hz_bubble", 14'd0);
    drive(1'b1, ADD, 1'b0, 1'b0);
    chk_rdy("hz_rdy_after", 1'b1);
    tick();
    chk("hz_add", exp_dec(ADD));

    // T4 multi-cycle MUL, DIV, MOD back-to-back then SUB
    run_multi("mul", MUL, 3);
    run_multi("div", DIV, 8);
    run_multi("mod", MOD, 8);
    drive(1'b1, SUB, 1'b0, 1'b0);
    chk_rdy("sub_rdy", 1'b1);
    tick();
    chk("sub_after", exp_dec(SUB));

    // T5 flush: branch beats hazard and drops STR
    drive(1'b1, BEQ, 1'b0, 1'b0);
    tick();
    chk("fl_beq", exp_dec(BEQ));
    drive(1'b1, STR, 1'b1, 1'b1);
    chk_rdy("fl_rdy", 1'b1);
    tick();
    chk("fl_cleared", 14'd0);

    // T6 reset on DIV EX cycle 4
    drive(1'b1, DIV, 1'b0, 1'b0);
    tick();
    drive(1'b0, ADD, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("r6_div_ex4", {exp_dec(DIV)[13:4], 1'b0, 3'b001});
    rst_n = 1'b0;
    drive(1'b1, ADD, 1'b0, 1'b0);
    chk_rdy("r6_rdy_rst", 1'b0);
    tick();
    chk("r6_cleared", 14'd0);
    rst_n = 1'b1;
    #2;
    chk_rdy("r6_rdy_run", 1'b1);
    tick();
    chk("r6_add", exp_dec(ADD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
